// File: rtl/bcd_countdown_timer.sv
// BCD MM:SS countdown timer with load/start/stop control and a one-second prescaler.
// Optional feature macro COUNTDOWN_AUTO_RELOAD_EN: reload from the shadow register at 00:00 and keep running.
module bcd_countdown_timer #(
  parameter int TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] preset,
  input  logic        load,
  input  logic        start,
  input  logic        stop,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic        running,
  output logic        done,
  output logic        expired
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   count_q, count_d;
  logic          done_q, done_d;
  logic [15:0]   preset_clamped;
  logic [15:0]   count_dec;

  // Digit 1 (sec_tens) saturates at 5, all others at 9.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_clamp
      localparam logic [3:0] LIM = (gi == 1) ? 4'd5 : 4'd9;
      assign preset_clamped[gi*4 +: 4] = (preset[gi*4 +: 4] > LIM) ? LIM : preset[gi*4 +: 4];
    end
  endgenerate

  // One-second decrement with borrow; never evaluated at 00:00 while running.
  always_comb begin
    count_dec = count_q;
    if (count_q[3:0] != 4'd0) begin
      count_dec[3:0] = count_q[3:0] - 4'd1;
    end else begin
      count_dec[3:0] = 4'd9;
      if (count_q[7:4] != 4'd0) begin
        count_dec[7:4] = count_q[7:4] - 4'd1;
      end else begin
        count_dec[7:4] = 4'd5;
        if (count_q[11:8] != 4'd0) begin
          count_dec[11:8] = count_q[11:8] - 4'd1;
        end else begin
          count_dec[11:8]  = 4'd9;
          count_dec[15:12] = count_q[15:12] - 4'd1;
        end
      end
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [15:0] shadow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= 16'h0000;
    end else if (load) begin
      shadow_q <= preset_clamped;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (load) begin
      count_d = preset_clamped;
      presc_d = '0;
      state_d = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (start) begin
      if ((state_q == ST_IDLE || state_q == ST_PAUSE) && count_q != 16'h0000) state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        count_d = count_dec;
        if (count_dec == 16'h0000) begin
          done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          count_d = shadow_q;
`else
          state_d = ST_EXPIRED;
`endif
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      count_q <= 16'h0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = count_q;
  assign running = (state_q == ST_RUN);
  assign expired = (state_q == ST_EXPIRED);
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomized and directed bench for bcd_countdown_timer, checked against a seconds-based reference model.
module tb_bcd_countdown_timer;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] preset = 16'h0000;
  logic        load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
  logic        running, done, expired;
  logic [15:0] digits;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: count held as total seconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  int m_state, m_secs, m_shadow, m_presc;
  bit m_done;

  bcd_countdown_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .preset(preset), .load(load), .start(start), .stop(stop),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .done(done), .expired(expired)
  );

  assign digits = {min_tens, min_ones, sec_tens, sec_ones};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int clamp_secs(input logic [15:0] p);
    int mt, mo, st, so;
    mt = min_int(int'(p[15:12]), 9);
    mo = min_int(int'(p[11:8]), 9);
    st = min_int(int'(p[7:4]), 5);
    so = min_int(int'(p[3:0]), 9);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    logic [3:0] a, b, c, d;
    a = 4'(s / 600);
    b = 4'((s / 60) % 10);
    c = 4'((s % 60) / 10);
    d = 4'(s % 10);
    return {a, b, c, d};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_secs = 0; m_shadow = 0; m_presc = 0; m_done = 0;
  endtask

  task automatic model_step(input bit ld, input bit st, input bit sp, input logic [15:0] pre);
    m_done = 0;
    if (ld) begin
      m_secs = clamp_secs(pre); m_shadow = m_secs; m_presc = 0; m_state = M_IDLE;
    end else if (sp) begin
      if (m_state == M_RUN) m_state = M_PAUSE;
    end else if (st) begin
      if ((m_state == M_IDLE || m_state == M_PAUSE) && m_secs != 0) m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (m_presc == TD - 1) begin
        m_presc = 0;
        m_secs--;
        if (m_secs == 0) begin
          m_done = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          m_secs = m_shadow;
`else
          m_state = M_EXP;
`endif
        end
      end else begin
        m_presc++;
      end
    end
  endtask

  task automatic check_outputs();
    check("digits", 32'(digits), 32'(to_bcd(m_secs)));
    check("running", 32'(running), 32'(m_state == M_RUN));
    check("done", 32'(done), 32'(m_done));
    check("expired", 32'(expired), 32'(m_state == M_EXP));
  endtask

  task automatic cycle(input bit ld, input bit st, input bit sp, input logic [15:0] pre);
    load = ld; start = st; stop = sp; preset = pre;
    @(posedge clk);
    if (reset) model_step(ld, st, sp, pre);
    #1;
    cyc++;
    check_outputs();
    $display("cyc %0d ld=%0b st=%0b sp=%0b pre=%04h digits=%04h run=%0b done=%0b exp=%0b",
             cyc, ld, st, sp, pre, digits, running, done, expired);
    load = 0; start = 0; stop = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, preset);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] rp;
    bit rl, rs, rt;
    model_reset();
    #1;
    check_outputs();
    check("rst_running", 32'(running), 32'h0);
    check("rst_expired", 32'(expired), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Load and borrow across tens and minutes
    cycle(1, 0, 0, 16'h0102);
    check("load_0102", 32'(digits), 32'h0102);
    check("load_idle", 32'(running), 32'h0);
    cycle(0, 1, 0, 16'h0102);
    check("start_run", 32'(running), 32'h1);
    idle(4);
    check("t4_0101", 32'(digits), 32'h0101);
    idle(4);
    check("t8_0100", 32'(digits), 32'h0100);
    idle(4);
    check("t12_0059", 32'(digits), 32'h0059);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // Done pulse and expiry
    cycle(1, 0, 0, 16'h0002);
    cycle(0, 1, 0, 16'h0002);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 0, 16'h0002);
      check("done_at8", 32'(done), 32'(i == 8));
    end
    check("zero_at_done", 32'(digits), 32'h0000);
    idle(1);
    check("expired_hold", 32'(expired), 32'h1);
    check("done_once", 32'(done), 32'h0);
    cycle(0, 1, 0, 16'h0002);
    check("exp_start_ign", 32'(expired), 32'h1);
    cycle(0, 0, 1, 16'h0002);
    check("exp_stop_ign", 32'(expired), 32'h1);
`else
    // Auto-reload keeps running with periodic done
    cycle(1, 0, 0, 16'h0002);
    cycle(0, 1, 0, 16'h0002);
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 0, 0, 16'h0002);
      check("ar_done", 32'(done), 32'(i % 8 == 0));
      check("ar_running", 32'(running), 32'h1);
      check("ar_expired", 32'(expired), 32'h0);
    end
    check("ar_reload", 32'(digits), 32'h0002);
`endif

    // Pause holds prescaler
    cycle(1, 0, 0, 16'h0005);
    cycle(0, 1, 0, 16'h0005);
    idle(2);
    cycle(0, 0, 1, 16'h0005);
    check("paused", 32'(running), 32'h0);
    idle(10);
    check("pause_hold", 32'(digits), 32'h0005);
    cycle(0, 1, 0, 16'h0005);
    idle(1);
    check("resume_1", 32'(digits), 32'h0005);
    idle(1);
    check("resume_2", 32'(digits), 32'h0004);
    cycle(0, 1, 1, 16'h0005);
    check("start_stop_pause", 32'(running), 32'h0);

    // Clamp, zero start, mid-count reset
    cycle(1, 0, 0, 16'hAB7F);
    check("clamp_9959", 32'(digits), 32'h9959);
    cycle(1, 0, 0, 16'h0000);
    cycle(0, 1, 0, 16'h0000);
    check("zero_start_ign", 32'(running), 32'h0);
    cycle(1, 0, 0, 16'h0003);
    cycle(0, 1, 0, 16'h0003);
    idle(5);
    pulse_reset();
    idle(3);
    check("post_rst_idle", 32'(running), 32'h0);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      rl = ($urandom_range(0, 99) < 4);
      rs = ($urandom_range(0, 99) < 15);
      rt = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 1) == 1) rp = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom)};
      else rp = 16'($urandom);
      cycle(rl, rs, rt, rp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, giving the number of clk cycles per one-second decrement (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port preset, input, 16 bits: BCD MM:SS load value as {min_tens, min_ones, sec_tens, sec_ones}.
REQ-005 The block SHALL have port load, input, 1 bit: one-cycle request to copy preset into the digits.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle request to begin or resume counting.
REQ-007 The block SHALL have port stop, input, 1 bit: one-cycle request to pause counting.
REQ-008 The block SHALL have ports min_tens, min_ones, sec_tens, sec_ones, output, 4 bits each: current BCD digits.
REQ-009 The block SHALL have port running, output, 1 bit: high while in state RUN.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when the count reaches 00:00.
REQ-011 The block SHALL have port expired, output, 1 bit: high while in state EXPIRED.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE and EXPIRED.
REQ-013 A load in any state SHALL copy preset into the digits and the shadow register, clear the prescaler and enter IDLE on the next edge.
REQ-014 On load, a digit above 9 SHALL be clamped to 9, and a sec_tens value above 5 SHALL be clamped to 5.
REQ-015 Priority SHALL be load > stop > start; a start and a stop in the same cycle SHALL act as stop.
REQ-016 A start in IDLE or PAUSE with a nonzero count SHALL enter RUN on the next edge; a start with a count of 00:00, or in RUN or EXPIRED, SHALL be ignored.
REQ-017 A stop in RUN SHALL enter PAUSE; the prescaler value SHALL be held in PAUSE and resumed on restart.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, and the terminal value SHALL produce a tick and wrap to 0.
REQ-019 On a tick the count SHALL decrement by one second.
REQ-020 On decrement, sec_ones 0->9 SHALL borrow from sec_tens, sec_tens 0->5 SHALL borrow from min_ones, and min_ones 0->9 SHALL borrow from min_tens.
REQ-021 A tick that yields 00:00 SHALL assert done for exactly one cycle, coincident with the zero digits, and enter EXPIRED.
REQ-022 The first decrement SHALL occur TICK_DIV cycles after the edge that enters RUN from a cleared prescaler.
REQ-023 EXPIRED SHALL hold 00:00 until load; start and stop SHALL be ignored in EXPIRED.
REQ-024 Maximum count SHALL be 99:59, and the digits SHALL never show a non-BCD value or a sec_tens value above 5.

Reset
REQ-025 reset low SHALL immediately force state IDLE, prescaler 0, all digits and the shadow register 0, and running, done and expired 0.
REQ-026 A reset asserted mid-count SHALL discard the count with no done pulse; operation SHALL resume on the first edge after reset deasserts.

Configuration
REQ-027 With macro COUNTDOWN_AUTO_RELOAD_EN defined, reaching 00:00 SHALL pulse done, reload the digits from the shadow register on the same edge and remain in RUN, and expired SHALL stay 0.
REQ-028 With COUNTDOWN_AUTO_RELOAD_EN undefined, the block SHALL enter EXPIRED per REQ-021; the shadow register MAY be omitted.

Verification (TICK_DIV=4)
REQ-029 The bench SHALL cover: reset low, then preset=16'h0102 and load -> digits 0,1,0,2; running=0.
REQ-030 The bench SHALL cover: start -> running=1; after 4 cycles 01:01, 8 cycles 01:00, 12 cycles 00:59 (borrow across tens and minutes).
REQ-031 The bench SHALL cover: preset=16'h0002, start -> done pulses once after 8 cycles with 00:00, then expired=1; a further start is ignored.
REQ-032 The bench SHALL cover: stop 2 cycles into a second, hold 10 cycles, then start -> the next decrement occurs 2 cycles after restart with no change during the pause; start and stop together in RUN -> PAUSE.
REQ-033 The bench SHALL cover: preset=16'hAB7F, load -> 99:59; start at 00:00 -> ignored; reset low mid-count -> 00:00, done=0.
REQ-034 The bench SHALL cover, with COUNTDOWN_AUTO_RELOAD_EN: preset 00:02 -> done pulses every 8 cycles, digits reload to 00:02, running stays 1.
